// File: rtl/uart_tx_pkg.sv
// Shared types and line levels for the UART transmit serializer.
package uart_tx_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } tx_state_e;

  localparam logic PAR_EVEN    = 1'b0;
  localparam logic PAR_ODD     = 1'b1;
  localparam logic IDLE_LEVEL  = 1'b1;
  localparam logic START_LEVEL = 1'b0;

  // Parity bit from the XOR-reduction of the payload and the parity type.
  function automatic logic parity_bit(input logic red_xor, input logic typ);
    logic r;
    case (typ)
      PAR_EVEN: r = red_xor;
      PAR_ODD:  r = ~red_xor;
      default:  r = red_xor;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/uart_tx_bit_timer.sv
// Bit-period timer: counts 0..period-1 in every non-idle state and
// tracks which payload bit is on the line during the DATA state.
module uart_tx_bit_timer
  import uart_tx_pkg::*;
#(
  parameter  int DATA_WIDTH = 8,
  parameter  int PRESCALE_W = 6,
  localparam int IDX_W      = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clear,      // frame accepted: restart both counters
  input  logic                  run,        // FSM is outside IDLE
  input  logic                  in_data,    // FSM is in DATA
  input  logic [PRESCALE_W-1:0] period,     // already clamped to >= 1
  output logic                  bit_tick,
  output logic                  last_data_bit,
  output logic [IDX_W-1:0]      bit_idx
);

  logic [PRESCALE_W-1:0] cnt_q, cnt_d;
  logic [IDX_W-1:0]      idx_q, idx_d;

  assign bit_tick      = run && (cnt_q == (period - 1'b1));
  assign last_data_bit = (idx_q == IDX_W'(DATA_WIDTH - 1));
  assign bit_idx       = idx_q;

  // Next-count logic: wrap the cycle counter on each tick, step the bit index in DATA.
  always_comb begin
    cnt_d = cnt_q;
    idx_d = idx_q;
    if (clear) begin
      cnt_d = '0;
      idx_d = '0;
    end else if (run) begin
      if (bit_tick) begin
        cnt_d = '0;
        if (in_data) idx_d = last_data_bit ? '0 : idx_q + 1'b1;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  // Counter registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
      idx_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      idx_q <= idx_d;
    end
  end

endmodule

// File: rtl/uart_tx_serializer.sv
// UART transmit serializer: start, LSB-first data, optional parity, stop.
// Optional error injection (INJ_PAR_ERR / INJ_STP_ERR ports) is enabled by
// defining UART_TX_ERR_INJ_EN.
module uart_tx_serializer
  import uart_tx_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int PRESCALE_W = 6
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [DATA_WIDTH-1:0] P_DATA,
  input  logic                  DATA_VALID,
  input  logic                  PAR_EN,
  input  logic                  PAR_TYP,
  input  logic [PRESCALE_W-1:0] PRESCALE,
`ifdef UART_TX_ERR_INJ_EN
  input  logic                  INJ_PAR_ERR,
  input  logic                  INJ_STP_ERR,
`endif
  output logic                  TX_OUT,
  output logic                  BUSY,
  output logic                  TX_DONE
);

  localparam int IDX_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

  tx_state_e             state_q, state_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic                  par_en_q, par_en_d;
  logic                  par_typ_q, par_typ_d;
  logic [PRESCALE_W-1:0] period_q, period_d;
  logic                  tx_q, tx_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  inj_par_q, inj_par_d;
  logic                  inj_stp_q, inj_stp_d;
  logic                  inj_par_in, inj_stp_in;

  logic                  accept;
  logic                  bit_tick, last_data_bit;
  logic [IDX_W-1:0]      bit_idx, nxt_idx;
  logic                  par_lvl, stop_lvl;

`ifdef UART_TX_ERR_INJ_EN
  assign inj_par_in = INJ_PAR_ERR;
  assign inj_stp_in = INJ_STP_ERR;
`else
  assign inj_par_in = 1'b0;
  assign inj_stp_in = 1'b0;
`endif

  // Line levels come only from captured state, never from live inputs.
  assign nxt_idx  = bit_idx + 1'b1;
  assign par_lvl  = parity_bit(^data_q, par_typ_q) ^ inj_par_q;
  assign stop_lvl = IDLE_LEVEL ^ inj_stp_q;

  uart_tx_bit_timer #(
    .DATA_WIDTH (DATA_WIDTH),
    .PRESCALE_W (PRESCALE_W)
  ) u_timer (
    .clk           (CLK),
    .rst           (RST),
    .clear         (accept),
    .run           (state_q != IDLE),
    .in_data       (state_q == DATA),
    .period        (period_q),
    .bit_tick      (bit_tick),
    .last_data_bit (last_data_bit),
    .bit_idx       (bit_idx)
  );

  // FSM next state, capture and registered line level (value for the next cycle).
  always_comb begin
    state_d   = state_q;
    data_d    = data_q;
    par_en_d  = par_en_q;
    par_typ_d = par_typ_q;
    period_d  = period_q;
    inj_par_d = inj_par_q;
    inj_stp_d = inj_stp_q;
    tx_d      = tx_q;
    done_d    = 1'b0;
    accept    = 1'b0;
    case (state_q)
      IDLE: begin
        tx_d = IDLE_LEVEL;
        if (DATA_VALID && !busy_q) begin
          accept    = 1'b1;
          data_d    = P_DATA;
          par_en_d  = PAR_EN;
          par_typ_d = PAR_TYP;
          period_d  = (PRESCALE == '0) ? PRESCALE_W'(1) : PRESCALE;
          inj_par_d = inj_par_in;
          inj_stp_d = inj_stp_in;
          state_d   = START;
          tx_d      = START_LEVEL;
        end
      end
      START: if (bit_tick) begin
        state_d = DATA;
        tx_d    = data_q[0];
      end
      DATA: if (bit_tick) begin
        if (!last_data_bit) begin
          tx_d = data_q[nxt_idx];
        end else if (par_en_q) begin
          state_d = PARITY;
          tx_d    = par_lvl;
        end else begin
          state_d = STOP;
          tx_d    = stop_lvl;
        end
      end
      PARITY: if (bit_tick) begin
        state_d = STOP;
        tx_d    = stop_lvl;
      end
      STOP: if (bit_tick) begin
        state_d = IDLE;
        tx_d    = IDLE_LEVEL;
        done_d  = 1'b1;
      end
      default: begin
        state_d = IDLE;
        tx_d    = IDLE_LEVEL;
      end
    endcase
    busy_d = (state_d != IDLE);
  end

  // State and output registers; reset abandons any frame without TX_DONE.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q   <= IDLE;
      data_q    <= '0;
      par_en_q  <= 1'b0;
      par_typ_q <= 1'b0;
      period_q  <= PRESCALE_W'(1);
      inj_par_q <= 1'b0;
      inj_stp_q <= 1'b0;
      tx_q      <= IDLE_LEVEL;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      data_q    <= data_d;
      par_en_q  <= par_en_d;
      par_typ_q <= par_typ_d;
      period_q  <= period_d;
      inj_par_q <= inj_par_d;
      inj_stp_q <= inj_stp_d;
      tx_q      <= tx_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign TX_OUT  = tx_q;
  assign BUSY    = busy_q;
  assign TX_DONE = done_q;

endmodule

// File: tb/tb_uart_tx_serializer.sv
// Self-checking bench for uart_tx_serializer: fixed frame table, corner
// sequences (back-to-back, mid-frame reset) and random frames against a model.
module tb_uart_tx_serializer;

  logic       CLK = 1'b0;
  logic       RST;
  logic [7:0] P_DATA;
  logic       DATA_VALID;
  logic       PAR_EN;
  logic       PAR_TYP;
  logic [5:0] PRESCALE;
  logic       INJ_PAR_ERR;
  logic       INJ_STP_ERR;
  wire        TX_OUT, BUSY, TX_DONE;

  int checks   = 0;
  int failures = 0;

  uart_tx_serializer #(.DATA_WIDTH(8), .PRESCALE_W(6)) dut (
    .CLK         (CLK),
    .RST         (RST),
    .P_DATA      (P_DATA),
    .DATA_VALID  (DATA_VALID),
    .PAR_EN      (PAR_EN),
    .PAR_TYP     (PAR_TYP),
    .PRESCALE    (PRESCALE),
`ifdef UART_TX_ERR_INJ_EN
    .INJ_PAR_ERR (INJ_PAR_ERR),
    .INJ_STP_ERR (INJ_STP_ERR),
`endif
    .TX_OUT      (TX_OUT),
    .BUSY        (BUSY),
    .TX_DONE     (TX_DONE)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    string       nm;
    logic [7:0]  d;
    bit          pe;
    bit          pt;
    logic [5:0]  ps;
    logic [15:0] bits;   // frame bit k at index k
    int          n;
  } vec_t;

  vec_t tbl[3];

  task automatic chk(input string nm, input int cyc, input logic [2:0] act, input logic [2:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s cyc=%0d {tx,busy,done} got=%b want=%b", nm, cyc, act, exp);
    end
  endtask

  // Reference frame: start 0, data LSB first, optional parity, stop.
  function automatic void build(input logic [7:0] d, input bit pe, input bit pt,
                                input bit pinj, input bit sinj,
                                output logic [15:0] bits, output int n);
    bit odd_ones;
    bits = '0;
    n = 0;
    bits[n] = 1'b0; n++;
    for (int i = 0; i < 8; i++) begin bits[n] = d[i]; n++; end
    if (pe) begin
      odd_ones = ($countones(d) % 2) == 1;
      bits[n] = odd_ones ^ pt ^ pinj; n++;
    end
    bits[n] = !sinj; n++;
  endfunction

  // Request at a negedge, accepted at the next posedge, then scramble inputs.
  task automatic launch(input logic [7:0] d, input bit pe, input bit pt, input logic [5:0] ps,
                        input bit pinj, input bit sinj);
    @(negedge CLK);
    P_DATA = d; PAR_EN = pe; PAR_TYP = pt; PRESCALE = ps;
    INJ_PAR_ERR = pinj; INJ_STP_ERR = sinj;
    DATA_VALID = 1'b1;
    @(posedge CLK);
    #1;
    DATA_VALID = 1'b0;
    P_DATA = ~d; PAR_EN = ~pe; PAR_TYP = ~pt; PRESCALE = ps + 6'd3;
    INJ_PAR_ERR = ~pinj; INJ_STP_ERR = ~sinj;
  endtask

  // Called just after the acceptance edge; ends at the negedge of the first idle cycle.
  task automatic expect_frame(input logic [15:0] bits, input int n, input int ps, input string nm);
    int p;
    p = (ps == 0) ? 1 : ps;
    for (int k = 0; k < n * p; k++) begin
      @(negedge CLK);
      chk(nm, k, {TX_OUT, BUSY, TX_DONE}, {bits[k / p], 1'b1, 1'b0});
    end
    @(negedge CLK);
    chk({nm, "_done"}, n * p, {TX_OUT, BUSY, TX_DONE}, 3'b101);
  endtask

  initial begin
    logic [15:0] bits;
    int          n;
    logic [7:0]  d;
    bit          pe, pt, pinj, sinj;
    logic [5:0]  ps;

    tbl[0] = '{"a5_even_p1", 8'hA5, 1'b1, 1'b0, 6'd1, 16'b0000010101001010, 11};
    tbl[1] = '{"07_odd_p1",  8'h07, 1'b1, 1'b1, 6'd1, 16'b0000010000001110, 11};
    tbl[2] = '{"3c_nopar_p4", 8'h3C, 1'b0, 1'b0, 6'd4, 16'b0000001001111000, 10};

    // Reset, with a request held during reset that must be ignored.
    RST = 1'b1; DATA_VALID = 1'b1; P_DATA = 8'h00; PAR_EN = 1'b0; PAR_TYP = 1'b0;
    PRESCALE = 6'd1; INJ_PAR_ERR = 1'b0; INJ_STP_ERR = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge CLK);
      chk("reset", i, {TX_OUT, BUSY, TX_DONE}, 3'b100);
    end
    DATA_VALID = 1'b0;
    RST = 1'b0;
    @(negedge CLK);
    chk("post_reset_idle", 0, {TX_OUT, BUSY, TX_DONE}, 3'b100);

    // Fixed vectors.
    for (int t = 0; t < 3; t++) begin
      launch(tbl[t].d, tbl[t].pe, tbl[t].pt, tbl[t].ps, 1'b0, 1'b0);
      expect_frame(tbl[t].bits, tbl[t].n, int'(tbl[t].ps), tbl[t].nm);
      @(negedge CLK);
      chk({tbl[t].nm, "_idle"}, 0, {TX_OUT, BUSY, TX_DONE}, 3'b100);
    end

    // Request held across two frames; data changes mid-frame.
    @(negedge CLK);
    P_DATA = 8'h96; PAR_EN = 1'b1; PAR_TYP = 1'b1; PRESCALE = 6'd2; DATA_VALID = 1'b1;
    @(posedge CLK);
    #1;
    P_DATA = 8'h3B;
    build(8'h96, 1'b1, 1'b1, 1'b0, 1'b0, bits, n);
    expect_frame(bits, n, 2, "b2b_first");
    @(posedge CLK);
    #1;
    DATA_VALID = 1'b0;
    build(8'h3B, 1'b1, 1'b1, 1'b0, 1'b0, bits, n);
    expect_frame(bits, n, 2, "b2b_second");

    // Reset during data bit 3 (frame bit 4), then a clean frame.
    launch(8'h5A, 1'b1, 1'b0, 6'd2, 1'b0, 1'b0);
    build(8'h5A, 1'b1, 1'b0, 1'b0, 1'b0, bits, n);
    for (int k = 0; k < 9; k++) begin
      @(negedge CLK);
      chk("rst_mid_pre", k, {TX_OUT, BUSY, TX_DONE}, {bits[k / 2], 1'b1, 1'b0});
    end
    RST = 1'b1;
    @(negedge CLK);
    chk("rst_mid", 0, {TX_OUT, BUSY, TX_DONE}, 3'b100);
    RST = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge CLK);
      chk("rst_mid_quiet", k, {TX_OUT, BUSY, TX_DONE}, 3'b100);
    end
    launch(8'hC3, 1'b1, 1'b0, 6'd1, 1'b0, 1'b0);
    build(8'hC3, 1'b1, 1'b0, 1'b0, 1'b0, bits, n);
    expect_frame(bits, n, 1, "after_rst");

`ifdef UART_TX_ERR_INJ_EN
    launch(8'hA5, 1'b1, 1'b0, 6'd1, 1'b1, 1'b0);
    build(8'hA5, 1'b1, 1'b0, 1'b1, 1'b0, bits, n);
    expect_frame(bits, n, 1, "inj_par");
    launch(8'hA5, 1'b1, 1'b0, 6'd3, 1'b0, 1'b1);
    build(8'hA5, 1'b1, 1'b0, 1'b0, 1'b1, bits, n);
    expect_frame(bits, n, 3, "inj_stp");
    launch(8'h3C, 1'b0, 1'b0, 6'd2, 1'b1, 1'b0);
    build(8'h3C, 1'b0, 1'b0, 1'b1, 1'b0, bits, n);
    expect_frame(bits, n, 2, "inj_par_nopar");
`endif

    // Random frames.
    for (int r = 0; r < 40; r++) begin
      d  = 8'($urandom);
      pe = 1'($urandom);
      pt = 1'($urandom);
      ps = 6'($urandom_range(0, 5));
`ifdef UART_TX_ERR_INJ_EN
      pinj = 1'($urandom);
      sinj = ($urandom_range(0, 3) == 0);
`else
      pinj = 1'b0;
      sinj = 1'b0;
`endif
      launch(d, pe, pt, ps, pinj, sinj);
      build(d, pe, pt, pinj, sinj, bits, n);
      expect_frame(bits, n, int'(ps), $sformatf("rand%0d", r));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
